gpio_hex_uart_tx: RTL
=====================

# gpio_hex_uart_tx

Serial console for the CPU's GPIO output register. Every CPU write to the output port is captured into a small FIFO. Each captured word is then transmitted on a UART 8N1 line as eight uppercase ASCII hex digits followed by CR LF. It sits beside the CPU in the top level, taps the writeback-stage GPIO write strobe and data, and drives one FPGA pin. This gives hardware runs the same per-write visibility of the output register that simulation gets from console prints.

## Interface
Parameters:
- CLKS_PER_BIT, default 434 — clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- FIFO_DEPTH, default 4 — word entries in the capture FIFO; power of two, ≥ 2.

Ports:
- clk  input  1  — system clock; all logic rising-edge.
- rst  input  1  — synchronous, active-high reset.
- gpio_we  input  1  — CPU output-register write strobe (writeback stage), one cycle per write.
- gpio_wdata  input  32  — value written to the output register, valid when gpio_we = 1.
- tx  output  1  — UART serial line; idles high.
- busy  output  1  — high while a character is on the line or the FIFO is non-empty.
- overflow  output  1  — sticky; set when a write was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  — words currently queued (does not include the word being sent).

## Operation
- Push: at a rising edge with gpio_we = 1:
  - If fifo_count < FIFO_DEPTH (value before the edge), gpio_wdata is enqueued.
  - Otherwise the word is dropped and overflow is set. A pop on the same edge does not rescue the push.
- Pop: in IDLE with fifo_count > 0, the head word is loaded into the shift word and the char index is reset to 0.
  - Push and pop on the same edge are both honoured; the count is unchanged.
- Frame: 10 characters, sent in this order:
  - idx 0–7: hex digits, nibble [31:28] first down to [3:0].
  - idx 8: 0x0D; idx 9: 0x0A.
- Nibble encoding: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
- Character format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: FIFO non-empty (pop).
  - START → DATA: after CLKS_PER_BIT cycles.
  - DATA → STOP: after 8 bits.
  - STOP → START: idx < 9; idx increments, no idle gap.
  - STOP → START: idx = 9 and FIFO non-empty; pop the next word, no gap.
  - STOP → IDLE: idx = 9 and FIFO empty.
- Counters: bit-timer counts 0..CLKS_PER_BIT-1 and wraps; bit index 0..7; char index 0..9.
- tx is registered; it is driven low in START, shift[0] in DATA, high in STOP and IDLE.
- busy = (state ≠ IDLE) | (fifo_count ≠ 0).
- Reset values: state IDLE, tx 1, busy 0, overflow 0, fifo_count 0, all pointers and counters 0.
- Reset mid-frame:
  - tx returns high on the edge after rst is sampled high.
  - FIFO contents and overflow are discarded.
  - A truncated character on the line is acceptable.
- gpio_we during rst is ignored.

## Timing
- Write at edge E with FIFO empty and FSM in IDLE:
  - fifo_count = 1 after E.
  - Pop at E+1; fifo_count = 0 after E+1.
  - tx goes low after E+2.
- Per-character duration: 10 × CLKS_PER_BIT cycles.
- Per-word duration: 100 × CLKS_PER_BIT cycles, measured from tx falling to the end of the LF stop bit.
- Back-to-back queued words: the next start bit begins on the cycle immediately after the previous LF stop bit.
- overflow rises on the edge where the write is dropped and stays high until rst.
- Throughput limit: one word per 100 × CLKS_PER_BIT cycles. Sustained faster writes overflow after FIFO_DEPTH + 1 words.

## Test plan
(All scenarios use CLKS_PER_BIT = 4, FIFO_DEPTH = 4; a bench UART decoder samples mid-bit.)
- Single write 0x00000002 → bytes 30 30 30 30 30 30 30 32 0D 0A. tx low after write edge + 2. Frame lasts exactly 400 cycles; busy drops the cycle after the last stop bit.
- Single write 0xDEADBEEF → bytes 44 45 41 44 42 45 45 46 0D 0A. Every bit is held exactly 4 cycles; stop bits are high.
- Six writes on consecutive cycles (0x1…0x6) from idle → 0x1–0x5 are transmitted back-to-back with no gap between frames. 0x6 is dropped. overflow = 1 after the 6th edge; max fifo_count = 4.
- Write at the same edge as a pop with fifo_count = 4 → that write is dropped and overflow is set. A write at a pop edge with fifo_count = 3 → accepted; fifo_count stays 3.
- rst asserted mid-DATA of the 3rd character with 2 words queued → after the next edge: tx = 1, busy = 0, fifo_count = 0, overflow = 0. A later write 0xA5 → clean frame 30 30 30 30 30 30 41 35 0D 0A.
- gpio_we held high with data 0xFFFFFFFF during rst for 3 cycles → nothing queued, tx stays high, fifo_count = 0.

Source files
------------

// File: rtl/gpio_hex_uart_tx.sv
// Serial console for the CPU GPIO output register: each write is queued and
// sent on a UART 8N1 line as eight uppercase hex digits followed by CR LF.
module gpio_hex_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gpio_we,
    input  logic [31:0]                   gpio_wdata,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_reg, state_next;
    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [3:0]     char_idx_reg, char_idx_next;
    logic [7:0]     ch_reg, ch_next;
    logic           tx_reg, tx_next;
    logic           ovf_reg, ovf_next;
    logic [31:0]    word_reg;
    logic [31:0]    mem [FIFO_DEPTH];

    logic           fifo_full;
    logic           push_ok;
    logic           pop;
    logic           tick;
    logic [7:0]     cur_char;
    logic [7:0]     digit_ascii [8];

    assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
    assign push_ok   = gpio_we & ~rst & ~fifo_full;
    assign tick      = (timer_reg == TW'(CLKS_PER_BIT - 1));

    // Digit 0 is the most significant nibble.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            logic [3:0] nib;
            assign nib = word_reg[31 - 4*gi -: 4];
            assign digit_ascii[gi] = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
        end
    endgenerate

    always_comb begin
        cur_char = 8'h0A;
        if (char_idx_reg < 4'd8)
            cur_char = digit_ascii[char_idx_reg[2:0]];
        else if (char_idx_reg == 4'd8)
            cur_char = 8'h0D;
    end

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        bit_idx_next  = bit_idx_reg;
        char_idx_next = char_idx_reg;
        ch_next       = ch_reg;
        pop           = 1'b0;

        case (state_reg)
            IDLE: begin
                timer_next = '0;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    timer_next   = '0;
                    ch_next      = cur_char;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_next = '0;
                    ch_next    = {1'b0, ch_reg[7:1]};
                    if (bit_idx_reg == 3'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx_reg + 3'd1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_next = '0;
                    if (char_idx_reg != 4'd9) begin
                        char_idx_next = char_idx_reg + 4'd1;
                        state_next    = START;
                    end else if (count_reg != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop)
            char_idx_next = 4'd0;
    end

    // A full FIFO rejects the write even if a pop frees a slot on the same edge.
    always_comb begin
        wr_ptr_next = push_ok ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok && !pop)
            count_next = count_reg + CW'(1);
        else if (!push_ok && pop)
            count_next = count_reg - CW'(1);
        ovf_next = ovf_reg | (gpio_we & fifo_full);
    end

    // tx follows the registered state, so the line lags the FSM by one cycle.
    always_comb begin
        tx_next = 1'b1;
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = ch_reg[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            timer_reg    <= '0;
            bit_idx_reg  <= '0;
            char_idx_reg <= '0;
            ch_reg       <= '0;
            tx_reg       <= 1'b1;
            ovf_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            timer_reg    <= timer_next;
            bit_idx_reg  <= bit_idx_next;
            char_idx_reg <= char_idx_next;
            ch_reg       <= ch_next;
            tx_reg       <= tx_next;
            ovf_reg      <= ovf_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= gpio_wdata;
        if (pop)
            word_reg <= mem[rd_ptr_reg];
    end

    assign tx         = tx_reg;
    assign overflow   = ovf_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) | (count_reg != '0);

endmodule
